// File: rtl/pipe_scaler_pkg.sv
// pipe_scaler_pkg
//
// Shared helpers for the pipe_scaler slice:
//   - prod_w()      : width of the raw product of one data word and one coefficient
//   - is_sentinel() : true for the all-zeros / all-ones words that bypass scaling
//
// The beat struct depends on module parameters, so it is declared inside
// pipe_scaler itself. It is built from the field widths these helpers define.

package pipe_scaler_pkg;

    // Widest data word is_sentinel() can examine.
    localparam int SENT_MAX_W = 64;

    function automatic int prod_w(input int data_w, input int cf_w);
        return data_w + cf_w;
    endfunction

    // d arrives zero-extended from a w-bit word, so all-ones means the low w bits set.
    function automatic logic is_sentinel(input logic [SENT_MAX_W-1:0] d, input int w);
        logic [SENT_MAX_W-1:0] ones;
        ones = (w >= SENT_MAX_W) ? '1 : ((SENT_MAX_W'(1) << w) - SENT_MAX_W'(1));
        return (d == '0) || (d == ones);
    endfunction

endpackage

// File: rtl/pipe_scaler_lane.sv
// pipe_scaler_lane
//
// Combinational scaling of one data channel. Sentinel words (all-zeros,
// all-ones) pass through. Other words are multiplied by the coefficient and
// then either truncated or saturated.
//
// Optional feature macro: PIPE_SCALER_SAT_EN
//   defined   : an overflowing product clamps to all-ones and raises sat
//   undefined : the product is truncated to DATA_W bits and there is no sat port
//
// Ports:
//   d    in  DATA_W  channel word
//   cf   in  CF_W    unsigned coefficient
//   res  out DATA_W  scaled word
//   sat  out 1       saturation flag (only when PIPE_SCALER_SAT_EN is defined)

module pipe_scaler_lane
    import pipe_scaler_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int CF_W   = 2
)
(
    input  logic [DATA_W-1:0] d,
    input  logic [CF_W-1:0]   cf,
    output logic [DATA_W-1:0] res
`ifdef PIPE_SCALER_SAT_EN
    ,
    output logic              sat
`endif
);

    logic sentinel;
    assign sentinel = is_sentinel(SENT_MAX_W'(d), DATA_W);

`ifdef PIPE_SCALER_SAT_EN
    localparam int PROD_W = prod_w(DATA_W, CF_W);

    logic [PROD_W-1:0] prod;
    assign prod = PROD_W'(d) * PROD_W'(cf);

    // Any bit set above DATA_W means the scaled word no longer fits.
    always_comb begin
        res = prod[DATA_W-1:0];
        sat = 1'b0;
        if (sentinel) begin
            res = d;
        end else if (prod[PROD_W-1:DATA_W] != '0) begin
            res = '1;
            sat = 1'b1;
        end
    end
`else
    // Only the low DATA_W bits survive truncation, so a DATA_W-wide multiply suffices.
    logic [DATA_W-1:0] prod_lo;
    assign prod_lo = d * DATA_W'(cf);
    assign res     = sentinel ? d : prod_lo;
`endif

endmodule

// File: rtl/pipe_scaler.sv
// pipe_scaler
//
// A STAGES-deep valid/ready pipeline that scales CH data words by a per-beat
// coefficient. The multiply happens in stage 0. Later stages only register
// the beat. A synchronous flush drops every beat in flight.
//
// Optional feature macro: PIPE_SCALER_SAT_EN (saturating results plus o_sat).
// When the macro is undefined, o_sat is tied to zero.
//
// Ports:
//   clk      in   1          clock, rising edge
//   rst_n    in   1          synchronous active-low reset
//   i_valid  in   1          input beat valid
//   i_ready  out  1          input beat accepted when i_valid && i_ready
//   i_cf     in   CF_W       coefficient captured with the beat
//   i_data   in   CH*DATA_W  input words, channel k at [k*DATA_W +: DATA_W]
//   i_flush  in   1          synchronous pipeline clear
//   o_valid  out  1          output beat valid
//   o_ready  in   1          downstream accept
//   o_data   out  CH*DATA_W  scaled words, same packing as i_data
//   o_sat    out  CH         per-channel saturation flags

module pipe_scaler
    import pipe_scaler_pkg::*;
#(
    parameter int CH     = 2,
    parameter int DATA_W = 16,
    parameter int CF_W   = 2,
    parameter int STAGES = 2
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [CF_W-1:0]      i_cf,
    input  logic [CH*DATA_W-1:0] i_data,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [CH*DATA_W-1:0] o_data,
    output logic [CH-1:0]        o_sat
);

    typedef struct packed {
        logic [CH*DATA_W-1:0] data;
`ifdef PIPE_SCALER_SAT_EN
        logic [CH-1:0]        sat;
`endif
    } beat_t;

    logic [CH*DATA_W-1:0] lane_data;
`ifdef PIPE_SCALER_SAT_EN
    logic [CH-1:0]        lane_sat;
`endif
    beat_t                lane_beat;

    beat_t                stage_q [STAGES];
    logic [STAGES-1:0]    vld;
    logic                 adv;
    logic                 accept;

    for (genvar k = 0; k < CH; k++) begin : g_lane
        pipe_scaler_lane #(
            .DATA_W (DATA_W),
            .CF_W   (CF_W)
        ) u_lane (
            .d   (i_data[k*DATA_W +: DATA_W]),
            .cf  (i_cf),
            .res (lane_data[k*DATA_W +: DATA_W])
`ifdef PIPE_SCALER_SAT_EN
            ,
            .sat (lane_sat[k])
`endif
        );
    end

    always_comb begin
        lane_beat      = '0;
        lane_beat.data = lane_data;
`ifdef PIPE_SCALER_SAT_EN
        lane_beat.sat  = lane_sat;
`endif
    end

    // The whole pipe moves together whenever the last stage is empty or being drained.
    assign adv     = o_ready || !o_valid;
    assign i_ready = adv && !i_flush;
    assign accept  = i_valid && i_ready;

    // Stage 0 always loads the lane result. Its valid bit decides whether
    // the loaded value is a real beat or a bubble. A flush clears only the
    // valid bits. The data registers keep their contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
        end else if (i_flush) begin
            vld <= '0;
        end else if (adv) begin
            for (int s = STAGES - 1; s >= 1; s--) begin
                vld[s]     <= vld[s-1];
                stage_q[s] <= stage_q[s-1];
            end
            vld[0]     <= accept;
            stage_q[0] <= lane_beat;
        end
    end

    assign o_valid = vld[STAGES-1];
    assign o_data  = stage_q[STAGES-1].data;
`ifdef PIPE_SCALER_SAT_EN
    assign o_sat   = stage_q[STAGES-1].sat;
`else
    assign o_sat   = '0;
`endif

endmodule

// File: doc/pipe_scaler.md
# pipe_scaler

Multi-channel, parametrised successor of the single-stage two-channel scaling pipe. Each accepted beat carries `CH` data words and one coefficient. Every word is scaled by the coefficient, except the sentinel values all-zeros and all-ones, which pass through unchanged. Beats travel through a `STAGES`-deep pipeline with valid/ready flow control and a synchronous flush. The block sits between an upstream sample source and downstream consumers that may apply back-pressure.

## Interface
Parameters:
- `CH`, default 2: number of data channels (≥1).
- `DATA_W`, default 16: width of each channel word (≥2).
- `CF_W`, default 2: coefficient width (≥1).
- `STAGES`, default 2: pipeline depth and latency in cycles (≥1).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `i_valid`  in  1  input beat valid.
- `i_ready`  out  1  input beat accepted when `i_valid && i_ready`.
- `i_cf`  in  `CF_W`  coefficient, unsigned, captured with the beat.
- `i_data`  in  `CH*DATA_W`  input words; channel k at `[k*DATA_W +: DATA_W]`.
- `i_flush`  in  1  synchronous pipeline clear.
- `o_valid`  out  1  output beat valid.
- `o_ready`  in  1  downstream accept.
- `o_data`  out  `CH*DATA_W`  scaled words, same channel packing as `i_data`.
- `o_sat`  out  `CH`  per-channel saturation indication for the current output beat.

## Operation
- Per channel, for input word d and coefficient c:
  - d = 0 or d = all-ones: result = d.
  - Otherwise: p = d*c, unsigned, `DATA_W+CF_W` bits wide.
- Default result is `p[DATA_W-1:0]` (truncation).
- Saturating behaviour applies only when `PIPE_SCALER_SAT_EN` is defined; see Configuration.
- c = 0 with a non-sentinel d gives 0.
- Pipeline advance condition: `adv = o_ready || !o_valid`.
- `i_ready = adv && !i_flush`. This is a combinational path from `o_ready` and `i_flush` to `i_ready`, and it is accepted.
- On `adv`:
  - Every stage shifts forward one position.
  - Stage 0 loads the accepted beat, or a bubble if no beat is accepted.
- While `!adv`, all stages and outputs hold their values.
- The coefficient travels with its beat. Changing `i_cf` never affects beats already in flight.
- Beats are emitted in acceptance order, with no loss and no duplication.
- `i_flush` has priority over everything except reset:
  - All stage valid bits clear on that edge.
  - No input is accepted in that cycle.
  - Data registers need not clear.
- Computation (multiply) happens in stage 0. Later stages are pure registers.

## Timing
- Reset (`rst_n`=0 at an edge): all valid bits = 0, `o_valid`=0, `o_data`=0, `o_sat`=0.
- `i_ready` follows its equation during reset; beats offered during reset are discarded.
- Latency: a beat accepted at edge n appears on `o_valid`/`o_data` after edge n+`STAGES-1`. This means it is visible `STAGES` cycles after `i_valid` is presented, when there is no stall.
- Throughput: one beat per cycle while `o_ready`=1.
- With `o_ready` held low, the pipe absorbs at most `STAGES` beats, then `i_ready` drops.
- Simultaneous output transfer and input acceptance in the same cycle is allowed when full.
- Reset or flush mid-stall: `o_valid` falls on the next edge, and the held beat is dropped.
- `o_data` and `o_sat` are stable while `o_valid && !o_ready`.

## Configuration
- Macro: `PIPE_SCALER_SAT_EN`.
- When defined:
  - If `p[DATA_W+CF_W-1:DATA_W]` ≠ 0, the result is all-ones.
  - The corresponding `o_sat` bit = 1 for that beat.
- When undefined:
  - Results are truncated.
  - `o_sat` is tied to 0.
  - No saturation logic is instantiated.
- Sentinel pass-through is identical in both builds.

## Structure
- Package `pipe_scaler_pkg` holds:
  - A function returning the sentinel test, `is_sentinel(d)`.
  - The beat struct typedef, generated per parameter set via a parameterised class or function helpers.
  - Localparam helpers for `PROD_W = DATA_W+CF_W`.
- Sub-module `pipe_scaler_lane`:
  - Combinational per-channel sentinel check, multiply, and truncate/saturate.
  - Instantiated `CH` times via a generate loop.
  - The top level owns the valid/ready chain and stage registers.

## Test plan
Configuration for all scenarios: `CH`=2, `DATA_W`=16, `CF_W`=2, `STAGES`=2.
- Reset: hold `rst_n`=0 for 3 cycles with `i_valid`=1 → `o_valid`=0, `o_data`=0, `o_sat`=0. The first output appears only after a post-reset accept.
- Sentinel/scale: `i_data`={0xFFFF, 0x0003}, `i_cf`=2 → 2 cycles later `o_data`={0xFFFF, 0x0006}. Then {0x0000, 0x1234} with cf=0 → {0x0000, 0x0000}.
- Overflow: ch0=0x9000, cf=3 → without macro 0xB000 and `o_sat`=0; with macro 0xFFFF and `o_sat[0]`=1.
- Back-pressure: stream 0x0001..0x0006 at cf=1 with `o_ready`=0 for cycles 2–7 → `i_ready` drops after 2 beats are held. All 6 values are emitted in order, with `o_data` stable while stalled.
- Flush: accept 2 beats, assert `i_flush` for 1 cycle with `i_valid`=1 → `o_valid`=0 next cycle, flushed beats are never emitted, and the flush-cycle beat is not accepted.
- Coefficient tagging: cf sequence 1, 2, 3 on consecutive beats of 0x0010 → outputs 0x0010, 0x0020, 0x0030.
